// File: rtl/seq_det_pkg.sv
// Shared types for the time-multiplexed "1001" detector: 2-bit Mealy state encoding.
package seq_det_pkg;

   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10,
      S3 = 2'b11
   } state_t;

endpackage

// File: rtl/seq_det_step.sv
// Combinational next-state/match step of the non-overlapping "1001" Mealy detector.
module seq_det_step
   import seq_det_pkg::*;
(
   input  state_t state,
   input  logic   din,
   output state_t next,
   output logic   match
);

   always_comb begin
      next  = S0;
      match = 1'b0;
      case (din)
         1'b0: begin
            case (state)
               S1:      next = S2;
               S2:      next = S3;
               default: next = S0;
            endcase
         end
         1'b1: begin
            // A completed match restarts the stream at S0 (no overlap).
            case (state)
               S3:      next = S0;
               default: next = S1;
            endcase
            match = (state == S3);
         end
         default: begin
            // Unknown bit: drop the partial sequence, never report a match.
            next  = S0;
            match = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one "1001" detector among N_CH serial streams.
// Optional per-channel saturating match counters when SEQ_MATCH_COUNT_EN is defined.
module seq_det_sched
   import seq_det_pkg::*;
#(
   parameter  int N_CH  = 4,
   parameter  int CNT_W = 8,
   localparam int CH_W  = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_CH-1:0]   req,
   input  logic [N_CH-1:0]   bit_in,
   input  logic [N_CH-1:0]   clear,
`ifdef SEQ_MATCH_COUNT_EN
   input  logic [CH_W-1:0]   cnt_sel,
   output logic [CNT_W-1:0]  cnt_out,
`endif
   output logic [N_CH-1:0]   grant,
   output logic              match_valid,
   output logic [CH_W-1:0]   match_ch
);

   logic [CH_W-1:0] ptr;
   logic [CH_W-1:0] gidx;
   logic            gvalid;
   logic [CH_W:0]   cand;
   state_t          ctx [N_CH];
   state_t          cur;
   state_t          nxt;
   logic            hit;
   logic            hit_rep;

   // Search from ptr upward with wrap; first requester wins.
   always_comb begin
      grant  = '0;
      gidx   = '0;
      gvalid = 1'b0;
      cand   = '0;
      if (!reset) begin
         for (int k = 0; k < N_CH; k++) begin
            cand = {1'b0, ptr} + (CH_W+1)'(k);
            if (cand >= (CH_W+1)'(N_CH))
               cand = cand - (CH_W+1)'(N_CH);
            if (!gvalid && req[cand[CH_W-1:0]]) begin
               gvalid = 1'b1;
               gidx   = cand[CH_W-1:0];
            end
         end
      end
      if (gvalid)
         grant[gidx] = 1'b1;
   end

   assign cur = ctx[gidx];

   seq_det_step u_step (
      .state (cur),
      .din   (bit_in[gidx]),
      .next  (nxt),
      .match (hit)
   );

   // A clear on the granted channel drops the consumed bit and its match.
   assign hit_rep = gvalid & hit & ~clear[gidx];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_CH; i++)
            ctx[i] <= S0;
         ptr         <= '0;
         match_valid <= 1'b0;
         match_ch    <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (clear[i])
               ctx[i] <= S0;
            else if (gvalid && gidx == CH_W'(i))
               ctx[i] <= nxt;
         end
         if (gvalid)
            ptr <= (gidx == CH_W'(N_CH-1)) ? '0 : gidx + 1'b1;
         match_valid <= hit_rep;
         if (hit_rep)
            match_ch <= gidx;
      end
   end

`ifdef SEQ_MATCH_COUNT_EN
   logic [CNT_W-1:0] cnt [N_CH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_CH; i++)
            cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (clear[i])
               cnt[i] <= '0;
            else if (hit_rep && gidx == CH_W'(i) && cnt[i] != '1)
               cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end

   assign cnt_out = cnt[cnt_sel];
`else
   // Counter width only matters with counters built in; keep it referenced.
   if (CNT_W < 1) begin : g_cnt_w_unused
   end
`endif

endmodule
